fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipelined MIPS core, directly upstream of the decode stage. Holds the program counter, presents the fetch address to instruction memory, selects the next PC (sequential or branch redirect resolved in decode), and owns the IF/ID pipeline register that supplies the decode stage's instruction and PCPlus4D inputs. Honours hazard-unit stall/flush controls and inserts bubbles while instruction memory is not ready.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, instruction word driven into decode for bubbles/flushes (sll $0,$0,0)
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- StallF  in  1  hazard unit: hold PC
- StallD  in  1  hazard unit: hold IF/ID register
- FlushD  in  1  hazard unit: clear IF/ID register to bubble
- PCSrcD  in  1  taken branch resolved in decode
- PCBranchD  in  32  branch target from decode
- imem_rdata  in  32  instruction word at imem_addr (combinational read)
- imem_ready  in  1  imem_rdata valid this cycle
- imem_addr  out  32  fetch address, equal to PCF
- PCF  out  32  current PC
- InstrD  out  32  IF/ID instruction to decode
- PCPlus4D  out  32  IF/ID PC+4 to decode
- ValidD  out  1  InstrD is a real fetched instruction (0 = bubble)
- FetchCount  out  32  instructions delivered into IF/ID since reset

## Operation
- PCPlus4F = PCF + 4, modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
- PCNext = PCSrcD ? {PCBranchD[31:2],2'b00} : PCPlus4F; PCBranchD[1:0] ignored.
- PC enable = ~StallF & (imem_ready | PCSrcD). Redirect abandons an outstanding not-ready fetch; no sequential advance without ready.
- IF/ID update, priority order each edge:
  - FlushD=1: InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0 (wins over StallD).
  - else StallD=1: hold all IF/ID outputs.
  - else imem_ready=1 and PCSrcD=0: InstrD=imem_rdata, PCPlus4D=PCPlus4F, ValidD=1, FetchCount+1.
  - else: bubble (NOP_INSTR, PCPlus4D=0, ValidD=0).
- The fetched word is discarded when PCSrcD=1 (wrong path) even without FlushD.
- FetchCount increments only on a ValidD=1 load; wraps 0xFFFF_FFFF -> 0.
- No internal FSM beyond PC/IF-ID registers; a fetch is "waiting" whenever imem_ready=0 and no redirect.

## Timing
- Reset (rst=0, async, any time): PCF=RESET_PC, InstrD=NOP_INSTR, PCPlus4D=0, ValidD=0, FetchCount=0, effective immediately, not waiting for clk. Release synchronous to next rising edge; first fetch at RESET_PC in first cycle after release.
- imem_addr is combinational from PCF; no registered read.
- Throughput: 1 instruction/cycle with imem_ready=1 and no stalls.
- Latency: word addressed in cycle n appears on InstrD in cycle n+1.
- Redirect: PCSrcD=1 in cycle n -> PCF=target in n+1, InstrD from target in n+2 (if ready).
- StallF=1 and PCSrcD=1 simultaneously: PC holds (stall wins); hazard unit must re-present the redirect.
- StallF=0, StallD=1: PC advances, IF/ID holds - legal only for hazard unit to avoid; block does not protect against lost instructions.
- Reset mid-wait (imem_ready=0): outstanding fetch dropped, PC returns to RESET_PC.

## Test plan
- Reset/sequential: rst low, release, imem_ready=1, rdata=addr^32'hA5A5_0000 -> PCF 0,4,8,12 on successive cycles; InstrD=0xA5A5_0000 at cycle 2, PCPlus4D=4, ValidD=1, FetchCount=3 after 4 edges.
- Wait states: imem_ready low 3 cycles at PCF=0x10 -> PCF held 0x10, ValidD=0, InstrD=NOP for 3 cycles, then InstrD=rdata@0x10, PCPlus4D=0x14.
- Redirect: at PCF=0x20 assert PCSrcD with PCBranchD=0x103 (+FlushD) -> next PCF=0x100, IF/ID bubble, following InstrD from 0x100, PCPlus4D=0x104.
- Stall/flush priority: StallF=StallD=1 two cycles -> PCF, InstrD, FetchCount frozen; StallD=1 with FlushD=1 -> ValidD=0, InstrD=NOP.
- Wrap: RESET_PC=0xFFFF_FFF8 -> PCF 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; PCPlus4D=0x0 for word at 0xFFFF_FFFC.
- Async reset mid-run: drop rst between edges at PCF=0x40 -> outputs reset immediately, before next clk edge.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Purpose : bundles fetch-stage hazard controls, branch redirect, imem port and IF/ID outputs.
// Latency : n/a (wiring only).
// Backpres: n/a; stalls are carried as StallF/StallD, imem wait states as imem_ready.
//
// Ports (master = fetch_stage side):
//   in : StallF, StallD, FlushD, PCSrcD, PCBranchD[31:0], imem_rdata[31:0], imem_ready
//   out: imem_addr[31:0], PCF[31:0], InstrD[31:0], PCPlus4D[31:0], ValidD, FetchCount[31:0]
interface fetch_stage_if;
    // hazard unit controls
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    // branch redirect resolved in decode
    logic        PCSrcD;
    logic [31:0] PCBranchD;
    // instruction memory
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] imem_addr;
    // program counter and IF/ID register
    logic [31:0] PCF;
    logic [31:0] InstrD;
    logic [31:0] PCPlus4D;
    logic        ValidD;
    logic [31:0] FetchCount;

    modport master (
        input  StallF, StallD, FlushD, PCSrcD, PCBranchD, imem_rdata, imem_ready,
        output imem_addr, PCF, InstrD, PCPlus4D, ValidD, FetchCount
    );

    modport slave (
        output StallF, StallD, FlushD, PCSrcD, PCBranchD, imem_rdata, imem_ready,
        input  imem_addr, PCF, InstrD, PCPlus4D, ValidD, FetchCount
    );
endinterface

// File: rtl/fetch_stage.sv
// Purpose : MIPS instruction-fetch stage: PC register, next-PC select, IF/ID pipeline register.
// Latency : word addressed in cycle n appears on InstrD in cycle n+1; 1 instr/cycle when ready.
// Backpres: StallF holds PC, StallD holds IF/ID; imem_ready=0 holds PC and injects bubbles.
//
// Ports:
//   clk           core clock, rising edge
//   rst           asynchronous active-low reset
//   fif (master)  hazard controls, branch redirect, imem address/data/ready, IF/ID outputs
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000   // sll $0,$0,0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master fif
);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

    logic [31:0] pc_q;
    logic [31:0] pc_plus4_f;
    logic [31:0] branch_tgt;
    logic [31:0] pc_next;
    logic        pc_en;

    ifid_t       ifid_q;
    ifid_t       ifid_d;
    logic        load_fetch;
    logic [31:0] fetch_cnt_q;

    // Branch targets are word aligned; the low address bits from decode carry no meaning.
    logic        unused_branch_lsbs;
    assign unused_branch_lsbs = ^fif.PCBranchD[1:0];

    // ------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------
    always_comb begin
        pc_plus4_f = pc_q + 32'd4;              // wraps naturally modulo 2^32
        branch_tgt = {fif.PCBranchD[31:2], 2'b00};
        pc_next    = fif.PCSrcD ? branch_tgt : pc_plus4_f;
        // A redirect abandons a fetch still waiting on imem; a sequential step
        // needs the current word to have actually arrived. StallF beats both,
        // so a redirect coinciding with StallF is lost and must be re-presented.
        pc_en      = ~fif.StallF & (fif.imem_ready | fif.PCSrcD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else if (pc_en) begin
            pc_q <= pc_next;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register: flush > stall > load > bubble
    // ------------------------------------------------------------------
    always_comb begin
        ifid_d     = ifid_q;
        load_fetch = 1'b0;
        if (fif.FlushD) begin
            ifid_d = IFID_BUBBLE;
        end else if (fif.StallD) begin
            ifid_d = ifid_q;
        end else if (fif.imem_ready && !fif.PCSrcD) begin
            // With a redirect in flight the word at PCF is wrong-path, so it is
            // dropped even if the hazard unit did not raise FlushD.
            ifid_d.instr    = fif.imem_rdata;
            ifid_d.pc_plus4 = pc_plus4_f;
            ifid_d.valid    = 1'b1;
            load_fetch      = 1'b1;
        end else begin
            ifid_d = IFID_BUBBLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ifid_q      <= IFID_BUBBLE;
            fetch_cnt_q <= 32'h0;
        end else begin
            ifid_q <= ifid_d;
            if (load_fetch) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fif.imem_addr  = pc_q;               // combinational read address, no extra register
    assign fif.PCF        = pc_q;
    assign fif.InstrD     = ifid_q.instr;
    assign fif.PCPlus4D   = ifid_q.pc_plus4;
    assign fif.ValidD     = ifid_q.valid;
    assign fif.FetchCount = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Purpose : self-checking bench for fetch_stage (scoreboard + directed checks, random stimulus).
// Latency : n/a.
// Backpres: n/a.
module tb_fetch_stage;

    logic clk;
    logic rst;

    fetch_stage_if bus ();
    fetch_stage_if wbus ();

    fetch_stage u_dut (
        .clk (clk),
        .rst (rst),
        .fif (bus)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_wrap (
        .clk (clk),
        .rst (rst),
        .fif (wbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Instruction memory: always-ready combinational ROM content.
    assign bus.imem_rdata  = mem_word(bus.imem_addr);
    assign wbus.imem_rdata = mem_word(wbus.imem_addr);

    // Wrap instance runs free: no stalls, memory always ready.
    assign wbus.StallF     = 1'b0;
    assign wbus.StallD     = 1'b0;
    assign wbus.FlushD     = 1'b0;
    assign wbus.PCSrcD     = 1'b0;
    assign wbus.PCBranchD  = 32'h0;
    assign wbus.imem_ready = 1'b1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pp4;
        logic [31:0] cnt;
        logic        valid;
    } snap_t;

    snap_t exp_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pp4;
    logic [31:0] m_cnt;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pp4   = 32'h0;
        m_valid = 1'b0;
        m_cnt   = 32'h0;
    endtask

    task automatic model_bubble();
        m_instr = 32'h0;
        m_pp4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // Drive one cycle of inputs; push the state expected during this cycle,
    // then advance the model across the coming rising edge.
    task automatic step(input logic sf, input logic sd, input logic fd, input logic ps,
                        input logic [31:0] tgt, input logic rdy);
        snap_t       s;
        logic [31:0] seq;
        bus.StallF     = sf;
        bus.StallD     = sd;
        bus.FlushD     = fd;
        bus.PCSrcD     = ps;
        bus.PCBranchD  = tgt;
        bus.imem_ready = rdy;
        s.pc    = m_pc;
        s.instr = m_instr;
        s.pp4   = m_pp4;
        s.cnt   = m_cnt;
        s.valid = m_valid;
        exp_q.push_back(s);
        seq = m_pc + 32'd4;
        if (fd) model_bubble();
        else if (sd) begin end
        else if (rdy && !ps) begin
            m_instr = mem_word(m_pc);
            m_pp4   = seq;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
        end else model_bubble();
        if (!sf && (rdy || ps)) m_pc = ps ? (tgt & 32'hFFFF_FFFC) : seq;
        @(posedge clk);
        #1;
    endtask

    task automatic seq_step();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    // Drop reset between edges and confirm outputs clear before any clock edge.
    task automatic async_reset_check(input string tag);
        #1 rst = 1'b0;
        #1;
        chk({tag, "_pcf"},   bus.PCF,             32'h0);
        chk({tag, "_instr"}, bus.InstrD,          32'h0);
        chk({tag, "_pp4"},   bus.PCPlus4D,        32'h0);
        chk({tag, "_valid"}, {31'h0, bus.ValidD}, 32'h0);
        chk({tag, "_cnt"},   bus.FetchCount,      32'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Scoreboard monitor: compares at the falling edge, away from updates.
    always @(negedge clk) begin
        snap_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pcf",   bus.PCF,             e.pc);
            chk("sb_addr",  bus.imem_addr,       e.pc);
            chk("sb_instr", bus.InstrD,          e.instr);
            chk("sb_pp4",   bus.PCPlus4D,        e.pp4);
            chk("sb_valid", {31'h0, bus.ValidD}, {31'h0, e.valid});
            chk("sb_cnt",   bus.FetchCount,      e.cnt);
        end
    end

    initial begin
        rst            = 1'b0;
        bus.StallF     = 1'b0;
        bus.StallD     = 1'b0;
        bus.FlushD     = 1'b0;
        bus.PCSrcD     = 1'b0;
        bus.PCBranchD  = 32'h0;
        bus.imem_ready = 1'b1;
        model_reset();

        // Reset state, held across an edge
        #12;
        chk("rst_pcf",   bus.PCF,             32'h0);
        chk("rst_instr", bus.InstrD,          32'h0);
        chk("rst_pp4",   bus.PCPlus4D,        32'h0);
        chk("rst_valid", {31'h0, bus.ValidD}, 32'h0);
        chk("rst_cnt",   bus.FetchCount,      32'h0);
        chk("w_rst_pcf", wbus.PCF,            32'hFFFF_FFF8);
        @(posedge clk);
        #1 rst = 1'b1;

        // Sequential fetch
        seq_step();
        chk("seq1_pcf",   bus.PCF,             32'h4);
        chk("seq1_instr", bus.InstrD,          32'hA5A5_0000);
        chk("seq1_pp4",   bus.PCPlus4D,        32'h4);
        chk("seq1_valid", {31'h0, bus.ValidD}, 32'h1);
        chk("w1_pcf",     wbus.PCF,            32'hFFFF_FFFC);
        seq_step();
        chk("w2_pcf",     wbus.PCF,            32'h0);
        chk("w2_instr",   wbus.InstrD,         32'h5A5A_FFFC);
        chk("w2_pp4",     wbus.PCPlus4D,       32'h0);
        chk("w2_valid",   {31'h0, wbus.ValidD}, 32'h1);
        seq_step();
        chk("seq3_pcf",   bus.PCF,             32'hC);
        chk("seq3_cnt",   bus.FetchCount,      32'h3);
        seq_step();
        chk("seq4_pcf",   bus.PCF,             32'h10);

        // Wait states at 0x10
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            chk("wait_pcf",   bus.PCF,             32'h10);
            chk("wait_valid", {31'h0, bus.ValidD}, 32'h0);
            chk("wait_instr", bus.InstrD,          32'h0);
        end
        seq_step();
        chk("wait_done_pcf",   bus.PCF,        32'h14);
        chk("wait_done_instr", bus.InstrD,     32'hA5A5_0010);
        chk("wait_done_pp4",   bus.PCPlus4D,   32'h14);
        chk("wait_done_cnt",   bus.FetchCount, 32'h5);

        // Redirect from 0x20 to unaligned target 0x103
        repeat (3) seq_step();
        chk("pre_redir_pcf", bus.PCF, 32'h20);
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0103, 1'b1);
        chk("redir_pcf",   bus.PCF,             32'h100);
        chk("redir_valid", {31'h0, bus.ValidD}, 32'h0);
        chk("redir_instr", bus.InstrD,          32'h0);
        seq_step();
        chk("redir2_pcf",   bus.PCF,        32'h104);
        chk("redir2_instr", bus.InstrD,     32'hA5A5_0100);
        chk("redir2_pp4",   bus.PCPlus4D,   32'h104);
        chk("redir2_cnt",   bus.FetchCount, 32'h9);

        // Full stall, then flush beating stall
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
            chk("stall_pcf",   bus.PCF,        32'h104);
            chk("stall_instr", bus.InstrD,     32'hA5A5_0100);
            chk("stall_cnt",   bus.FetchCount, 32'h9);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("flush_valid", {31'h0, bus.ValidD}, 32'h0);
        chk("flush_instr", bus.InstrD,          32'h0);
        chk("flush_pcf",   bus.PCF,             32'h108);

        // Async reset mid-run, then again at PCF=0x40
        async_reset_check("arst1");
        repeat (16) seq_step();
        chk("pre_arst_pcf", bus.PCF, 32'h40);
        async_reset_check("arst2");

        // Randomized traffic against the reference model
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 4) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 6) == 0,
                 $urandom,
                 $urandom_range(0, 9) < 7);
        end
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
